adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
//  Shares one N-bit adder datapath between R requesters.
//  Round-robin arbitration picks one requester per cycle and captures its operands.
//  The registered sum is returned with the winner's ID and final carry.
//  Sits between client blocks (accumulators, address generators) and the adder.
//  Two-stage pipeline (grant/capture, add/result) with result backpressure.
// PARAMETERS
//  N     32  operand and sum width in bits
//  R     4   number of requesters, >=2
//  IDW   2   ID width, = $clog2(R)
//  CNTW  16  width of the completed-operation counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  req         in   R      level request, one bit per requester
//  a_flat      in   R*N    operand A; requester i at [i*N +: N]
//  b_flat      in   R*N    operand B; requester i at [i*N +: N]
//  gnt         out  R      one-hot, 1-cycle pulse: operands of req i captured
//  res_ready   in   1      consumer accepts result this cycle
//  res_valid   out  1      result/res_id/res_carry valid
//  result      out  N      (A+B) mod 2^N
//  res_carry   out  1      carry out of bit N-1
//  res_id      out  IDW    index of requester that owns result
//  ops_done    out  CNTW   count of accepted results (res_valid & res_ready)
// BEHAVIOUR
//  Reset (async, immediate):
//   - All outputs and internal registers clear to 0; RR pointer = 0.
//   - Reset mid-operation discards in-flight ops and issues no gnt or res_valid.
//  stall = res_valid & ~res_ready.
//   - During stall, stage-1 and stage-2 registers hold.
//   - RR pointer holds; gnt = 0 next cycle.
//  Stage 0 (combinational):
//   - eligible = req & ~gnt. A requester pulsed this cycle cannot win again this cycle.
//   - Winner = first eligible index searching ptr, ptr+1, ..., R-1, 0, ..., ptr-1 (wrap).
//  Stage 1 edge (~stall & |eligible):
//   - gnt <= onehot(winner).
//   - op_a/op_b/op_id <= winner's operands/index; op_vld <= 1.
//   - ptr <= (winner==R-1) ? 0 : winner+1.
//  Stage 1 edge (~stall & ~|eligible): gnt <= 0, op_vld <= 0, ptr holds.
//  Stage 2 edge (~stall):
//   - {res_carry,result} <= op_a + op_b, computed N+1 bits wide.
//   - res_id <= op_id; res_valid <= op_vld.
//  Latency and throughput:
//   - req high in cycle t with no contention gives gnt in t+1 and res_valid in t+2.
//   - Up to 1 op/cycle when res_ready is held high.
//  Requester contract:
//   - Hold req and operands stable until gnt is seen.
//   - Deassert req in the gnt cycle unless another op is wanted.
//   - A req still high after gnt competes again from cycle gnt+1.
//  Result handshake:
//   - Result transfers on res_valid & res_ready.
//   - Held stable while stalled; no result is dropped or duplicated.
//  ops_done increments on each transfer and wraps 2^CNTW-1 -> 0.
//  Overflow: result wraps mod 2^N, res_carry=1; no saturation, no error flag.
// TESTING
//  1 Single op (N=32, R=4): req=0001, A=5, B=7.
//    -> gnt=0001 at t+1; res_valid at t+2 with result=12, carry=0, res_id=0.
//  2 Carry/wrap: A=32'hFFFFFFFF, B=1.
//    -> result=0, res_carry=1. A=B=32'h80000000 -> result=0, res_carry=1.
//  3 Round-robin: req=1111 held, res_ready=1.
//    -> gnt sequence 0001,0010,0100,1000,0001; res_id 0,1,2,3,0 each cycle.
//  4 Backpressure: 4 back-to-back ops, res_ready=0 for 3 cycles after the first res_valid.
//    -> result/res_id frozen, gnt=0 during stall.
//    -> all 4 results delivered in order, ops_done=4.
//  5 Reset mid-op: assert rst while op_vld=1 and res_valid=1.
//    -> all outputs 0 immediately, ptr=0.
//    -> after release, req=1000 gives gnt=1000 first.
//  6 Counter wrap (CNTW=4): 17 accepted results -> ops_done = 1.
//  Scoreboard: reference-model every transfer as {carry,sum} = A+B.
//  Check: at most one gnt bit high per cycle.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one N-bit adder among R requesters.
// Two-stage pipeline (grant/capture, add/result) with result backpressure.
module adder_share_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned R    = 4,
  parameter int unsigned IDW  = $clog2(R),
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    req,
  input  logic [R*N-1:0]  a_flat,
  input  logic [R*N-1:0]  b_flat,
  output logic [R-1:0]    gnt,
  input  logic            res_ready,
  output logic            res_valid,
  output logic [N-1:0]    result,
  output logic            res_carry,
  output logic [IDW-1:0]  res_id,
  output logic [CNTW-1:0] ops_done
);

  localparam int unsigned PW = IDW + 1;

  logic [IDW-1:0] ptr;
  logic [R-1:0]   eligible;
  logic [IDW-1:0] winner;
  logic           found;
  logic [PW-1:0]  idx;
  logic           stall;

  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] op_id;
  logic           op_vld;

  logic [N-1:0]   a_arr [R];
  logic [N-1:0]   b_arr [R];

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign a_arr[g] = a_flat[g*N +: N];
    assign b_arr[g] = b_flat[g*N +: N];
  end

  assign stall    = res_valid & ~res_ready;
  // A requester granted last edge sits out one round of arbitration
  assign eligible = req & ~gnt;

  // First eligible index starting at ptr, wrapping at R
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < R; k++) begin
      idx = {1'b0, ptr} + PW'(k);
      if (idx >= PW'(R)) idx = idx - PW'(R);
      if (!found && eligible[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      op_vld    <= 1'b0;
      result    <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (res_valid && res_ready) ops_done <= ops_done + CNTW'(1);
      if (stall) begin
        gnt <= '0;
      end else begin
        if (found) begin
          gnt    <= R'(1) << winner;
          op_a   <= a_arr[winner];
          op_b   <= b_arr[winner];
          op_id  <= winner;
          op_vld <= 1'b1;
          ptr    <= (winner == IDW'(R - 1)) ? '0 : winner + IDW'(1);
        end else begin
          gnt    <= '0;
          op_vld <= 1'b0;
        end
        {res_carry, result} <= {1'b0, op_a} + {1'b0, op_b};
        res_id              <= op_id;
        res_valid           <= op_vld;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter (N=32, R=4, CNTW=4).
module tb_adder_share_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [32:0] cs;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [31:0]  a_arr [4];
  logic [31:0]  b_arr [4];
  logic [127:0] a_flat;
  logic [127:0] b_flat;
  logic [3:0]   gnt;
  logic         res_ready = 1'b1;
  logic         res_valid;
  logic [31:0]  result;
  logic         res_carry;
  logic [1:0]   res_id;
  logic [3:0]   ops_done;

  int   total = 0;
  int   bad   = 0;
  exp_t sb [$];

  assign a_flat = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign b_flat = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  adder_share_arbiter #(.N(32), .R(4), .IDW(2), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .res_ready(res_ready), .res_valid(res_valid), .result(result),
    .res_carry(res_carry), .res_id(res_id), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and polices stalls/grants
  initial begin
    logic [3:0]  model_cnt;
    logic        prev_stall;
    logic [34:0] prev_out;
    exp_t        e;
    model_cnt  = '0;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_cnt  = '0;
        prev_stall = 1'b0;
      end else begin
        check("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
        if (prev_stall) begin
          check("stall_hold", {res_valid, res_id, res_carry, result}, {1'b1, prev_out});
          check("stall_gnt", 64'(gnt), 64'd0);
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got id=%0d res=%h want none", res_id, result);
          end else begin
            e = sb.pop_front();
            check("result", {res_id, res_carry, result}, {e.id, e.cs});
          end
          check("ops_done", 64'(ops_done), 64'(model_cnt));
          model_cnt = model_cnt + 4'd1;
        end
        prev_stall = res_valid && !res_ready;
        prev_out   = {res_id, res_carry, result};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic apply_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic push_exp(input int i, input logic [32:0] cs);
    exp_t e;
    e.id = 2'(i);
    e.cs = cs;
    sb.push_back(e);
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [32:0] exp_cs, input logic [3:0] exp_gnt);
    a_arr[i] = a;
    b_arr[i] = b;
    req[i]   = 1'b1;
    push_exp(i, exp_cs);
    step();
    check("gnt", 64'(gnt), 64'(exp_gnt));
  endtask

  initial begin
    logic [3:0] seq [5];
    int cyc;
    int stall_left;
    bit started;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    apply_reset();
    check("reset_outs", {gnt, res_valid, res_carry, res_id, result, ops_done}, 64'd0);

    // Single op: gnt at t+1, result at t+2
    do_op(0, 32'd5, 32'd7, 33'd12, 4'b0001);
    step();
    check("lat_valid", {res_valid, result}, {1'b1, 32'd12});
    drain();

    // Carry / wrap
    do_op(1, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000, 4'b0010);
    do_op(2, 32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, 4'b0100);
    drain();

    // Round-robin with all requesters held
    apply_reset();
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 32'(10 * (i + 1));
      b_arr[i] = 32'(i + 1);
    end
    push_exp(0, 33'd11);
    push_exp(1, 33'd22);
    push_exp(2, 33'd33);
    push_exp(3, 33'd44);
    push_exp(0, 33'd11);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("rr_gnt", 64'(gnt), 64'(seq[k]));
    end
    req = '0;
    drain();

    // Backpressure: 3-cycle stall after the first result
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      a_arr[i] = 32'(100 * (i + 1));
      b_arr[i] = 32'd5;
    end
    a_arr[3] = 32'hFFFF_FFF0;
    b_arr[3] = 32'h0000_0020;
    push_exp(0, 33'd105);
    push_exp(1, 33'd205);
    push_exp(2, 33'd305);
    push_exp(3, 33'h1_0000_0010);
    req = 4'b1111;
    res_ready = 1'b1;
    cyc = 0;
    stall_left = 0;
    started = 1'b0;
    while ((req != 0 || sb.size() != 0) && cyc < 60) begin
      step();
      cyc++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) res_ready = 1'b1;
      end else if (res_valid && !started) begin
        started = 1'b1;
        res_ready = 1'b0;
        stall_left = 3;
      end
    end
    check("bp_timeout", 64'(cyc < 60), 64'd1);
    step();
    check("bp_ops_done", 64'(ops_done), 64'd4);

    // Reset mid-operation, then ptr must restart at 0
    apply_reset();
    res_ready = 1'b0;
    req = 4'b1111;
    step();
    step();
    check("pre_rst_busy", 64'(res_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async", {gnt, res_valid, res_carry, res_id, result, ops_done}, 64'd0);
    req = '0;
    res_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held", {gnt, res_valid}, 64'd0);
    rst = 1'b0;
    a_arr[0] = 32'd1;
    b_arr[0] = 32'd2;
    a_arr[3] = 32'd40;
    b_arr[3] = 32'd2;
    push_exp(0, 33'd3);
    push_exp(3, 33'd42);
    req = 4'b1001;
    step();
    check("post_rst_gnt0", 64'(gnt), 64'b0001);
    step();
    check("post_rst_gnt1", 64'(gnt), 64'b1000);
    drain();

    // Counter wrap: 17 transfers on a 4-bit counter
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      a = 32'(k) * 32'd1000;
      b = 32'hFFFF_FF00 + 32'(k * 8);
      do_op(k % 4, a, b, {1'b0, a} + {1'b0, b}, 4'(1 << (k % 4)));
    end
    drain();
    step();
    check("cnt_wrap", 64'(ops_done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
